// File: rtl/eth_mac_stats_pkg.sv
// Shared constants and helpers for the per-channel MAC statistics block.
// Counter indices within a channel and the read-address index field width.
package eth_mac_stats_pkg;

    localparam int STAT_TX_PKT       = 0;
    localparam int STAT_TX_UNDERFLOW = 1;
    localparam int STAT_RX_PKT       = 2;
    localparam int STAT_RX_BAD_FRAME = 3;
    localparam int STAT_RX_BAD_FCS   = 4;

    localparam int STAT_NUM      = 5;
    localparam int STAT_IDX_BITS = 3;
    localparam int STAT_SLOTS    = 1 << STAT_IDX_BITS;

    // Lane-0 and lane-4 start pulses may both fire in one cycle.
    function automatic logic [1:0] pkt_inc(input logic [1:0] starts);
        return {1'b0, starts[0]} + {1'b0, starts[1]};
    endfunction

    function automatic logic [1:0] err_inc(input logic pulse);
        return {1'b0, pulse};
    endfunction

endpackage

// File: rtl/eth_stat_counter.sv
// One saturating statistics counter with a 0..2 increment per cycle,
// plus the shadow register it is copied into on a snapshot strobe.
module eth_stat_counter #(
    parameter int WIDTH         = 32,
    parameter bit CLEAR_ON_SNAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       inc,
    input  logic             snap,
    output logic [WIDTH-1:0] shadow,
    output logic             sat_evt
);

    logic [WIDTH-1:0] live;
    logic [WIDTH-1:0] live_inc;
    logic [WIDTH:0]   sum;

    // The carry out of the widened sum is the overflow indication.
    assign sum      = {1'b0, live} + {{(WIDTH-1){1'b0}}, inc};
    assign live_inc = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    assign sat_evt  = &live_inc;

    always_ff @(posedge clk) begin
        // NOTE: shadow registers are reset too, because software may read them before any snapshot.
        if (rst) begin
            live   <= '0;
            shadow <= '0;
        end else begin
            // NOTE: non-blocking assignments let shadow capture the pre-increment live value.
            if (snap) begin
                shadow <= live;
            end
            if (snap && CLEAR_ON_SNAP) begin
                live <= {{(WIDTH-2){1'b0}}, inc};
            end else begin
                live <= live_inc;
            end
        end
    end

endmodule

// File: rtl/eth_mac_stats.sv
// Per-channel MAC statistics: increment decode, saturating counter array,
// registered shadow-bank read port and sticky per-channel saturation flags.
module eth_mac_stats
    import eth_mac_stats_pkg::*;
#(
    parameter  int N_CHANNELS    = 4,
    parameter  int COUNTER_WIDTH = 32,
    parameter  int CLEAR_ON_SNAP = 1,
    localparam int CH_BITS       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*N_CHANNELS-1:0]    tx_start_packet,
    input  logic [N_CHANNELS-1:0]      tx_error_underflow,
    input  logic [2*N_CHANNELS-1:0]    rx_start_packet,
    input  logic [N_CHANNELS-1:0]      rx_error_bad_frame,
    input  logic [N_CHANNELS-1:0]      rx_error_bad_fcs,
    input  logic                       snap,
    input  logic                       rd_req,
    input  logic [CH_BITS+2:0]         rd_addr,
    output logic                       rd_valid,
    output logic [COUNTER_WIDTH-1:0]   rd_data,
    output logic [N_CHANNELS-1:0]      sat_flag
);

    localparam int ADDR_SLOTS = (1 << CH_BITS) * STAT_SLOTS;
    localparam bit CLEAR_BIT  = (CLEAR_ON_SNAP != 0);

    // Indexed directly by rd_addr; unpopulated slots read as zero.
    logic [COUNTER_WIDTH-1:0]       shadow_flat [ADDR_SLOTS];
    logic [N_CHANNELS*STAT_NUM-1:0] sat_evt;
    logic [N_CHANNELS-1:0]          sat_set;

    for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
        logic [1:0] inc [STAT_NUM];

        assign inc[STAT_TX_PKT]       = pkt_inc(tx_start_packet[2*ch +: 2]);
        assign inc[STAT_TX_UNDERFLOW] = err_inc(tx_error_underflow[ch]);
        assign inc[STAT_RX_PKT]       = pkt_inc(rx_start_packet[2*ch +: 2]);
        assign inc[STAT_RX_BAD_FRAME] = err_inc(rx_error_bad_frame[ch]);
        assign inc[STAT_RX_BAD_FCS]   = err_inc(rx_error_bad_fcs[ch]);

        for (genvar idx = 0; idx < STAT_NUM; idx++) begin : g_stat
            eth_stat_counter #(
                .WIDTH         (COUNTER_WIDTH),
                .CLEAR_ON_SNAP (CLEAR_BIT)
            ) u_cnt (
                .clk     (clk),
                .rst     (rst),
                .inc     (inc[idx]),
                .snap    (snap),
                .shadow  (shadow_flat[ch*STAT_SLOTS + idx]),
                .sat_evt (sat_evt[ch*STAT_NUM + idx])
            );
        end

        assign sat_set[ch] = |sat_evt[ch*STAT_NUM +: STAT_NUM];
    end

    for (genvar slot = 0; slot < ADDR_SLOTS; slot++) begin : g_empty
        if ((slot / STAT_SLOTS) >= N_CHANNELS || (slot % STAT_SLOTS) >= STAT_NUM) begin : g_zero
            assign shadow_flat[slot] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= '0;
        end else if (snap && CLEAR_BIT) begin
            sat_flag <= '0;
        end else begin
            sat_flag <= sat_flag | sat_set;
        end
    end

    // A read coinciding with snap sees the shadow bank before it reloads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= shadow_flat[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_eth_mac_stats.sv
// Scoreboard bench: two DUTs (clear-on-snap and free-running) share stimulus;
// a reference model pushes expected read data, a negedge monitor pops and compares.
module tb_eth_mac_stats;
    import eth_mac_stats_pkg::*;

    localparam int N_CH = 3;
    localparam int W    = 8;
    localparam int AW   = 2 + 3;
    localparam int MAXV = (1 << W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*N_CH-1:0] tx_start_packet, rx_start_packet;
    logic [N_CH-1:0]   tx_error_underflow, rx_error_bad_frame, rx_error_bad_fcs;
    logic              snap, rd_req;
    logic [AW-1:0]     rd_addr;

    logic              rd_valid_c, rd_valid_f;
    logic [W-1:0]      rd_data_c, rd_data_f;
    logic [N_CH-1:0]   sat_flag_c, sat_flag_f;

    int checks   = 0;
    int failures = 0;

    // Model state; mode 0 = clear-on-snap, mode 1 = free-running.
    int live   [2][N_CH][STAT_NUM];
    int shadow [2][N_CH][STAT_NUM];
    bit sat    [2][N_CH];
    int last   [2];
    int exp_q0 [$];
    int exp_q1 [$];

    eth_mac_stats #(.N_CHANNELS(N_CH), .COUNTER_WIDTH(W), .CLEAR_ON_SNAP(1)) dut_c (
        .clk(clk), .rst(rst),
        .tx_start_packet(tx_start_packet), .tx_error_underflow(tx_error_underflow),
        .rx_start_packet(rx_start_packet), .rx_error_bad_frame(rx_error_bad_frame),
        .rx_error_bad_fcs(rx_error_bad_fcs), .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid_c), .rd_data(rd_data_c), .sat_flag(sat_flag_c)
    );

    eth_mac_stats #(.N_CHANNELS(N_CH), .COUNTER_WIDTH(W), .CLEAR_ON_SNAP(0)) dut_f (
        .clk(clk), .rst(rst),
        .tx_start_packet(tx_start_packet), .tx_error_underflow(tx_error_underflow),
        .rx_start_packet(rx_start_packet), .rx_error_bad_frame(rx_error_bad_frame),
        .rx_error_bad_fcs(rx_error_bad_fcs), .snap(snap), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid_f), .rd_data(rd_data_f), .sat_flag(sat_flag_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int ev(input int ch, input int idx);
        case (idx)
            STAT_TX_PKT:       return int'(tx_start_packet[2*ch]) + int'(tx_start_packet[2*ch+1]);
            STAT_TX_UNDERFLOW: return int'(tx_error_underflow[ch]);
            STAT_RX_PKT:       return int'(rx_start_packet[2*ch]) + int'(rx_start_packet[2*ch+1]);
            STAT_RX_BAD_FRAME: return int'(rx_error_bad_frame[ch]);
            default:           return int'(rx_error_bad_fcs[ch]);
        endcase
    endfunction

    // Reference model: evaluated once per rising edge from the spec's rules.
    always @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 2; m++) begin
                last[m] = 0;
                for (int ch = 0; ch < N_CH; ch++) begin
                    sat[m][ch] = 1'b0;
                    for (int i = 0; i < STAT_NUM; i++) begin
                        live[m][ch][i]   = 0;
                        shadow[m][ch][i] = 0;
                    end
                end
            end
        end else begin
            if (rd_req) begin
                int rch, ridx, v0, v1;
                rch  = int'(rd_addr) / 8;
                ridx = int'(rd_addr) % 8;
                v0 = 0;
                v1 = 0;
                if (rch < N_CH && ridx < STAT_NUM) begin
                    v0 = shadow[0][rch][ridx];
                    v1 = shadow[1][rch][ridx];
                end
                exp_q0.push_back(v0);
                exp_q1.push_back(v1);
            end
            for (int m = 0; m < 2; m++) begin
                for (int ch = 0; ch < N_CH; ch++) begin
                    for (int i = 0; i < STAT_NUM; i++) begin
                        int inc, nv;
                        inc = ev(ch, i);
                        nv  = live[m][ch][i] + inc;
                        if (nv > MAXV) nv = MAXV;
                        if (snap) shadow[m][ch][i] = live[m][ch][i];
                        if (snap && m == 0) begin
                            live[m][ch][i] = inc;
                        end else begin
                            live[m][ch][i] = nv;
                            if (nv == MAXV) sat[m][ch] = 1'b1;
                        end
                    end
                    if (snap && m == 0) sat[m][ch] = 1'b0;
                end
            end
        end
    end

    task automatic mon(input int m, input logic v, input logic [W-1:0] d, input logic [N_CH-1:0] sf);
        bit have;
        have = (m == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        check($sformatf("rd_valid_m%0d", m), longint'(v), longint'(have));
        if (have) last[m] = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("rd_data_m%0d", m), longint'(d), longint'(last[m]));
        for (int ch = 0; ch < N_CH; ch++)
            check($sformatf("sat_flag_m%0d_ch%0d", m, ch), longint'(sf[ch]), longint'(sat[m][ch]));
    endtask

    always @(negedge clk) begin
        mon(0, rd_valid_c, rd_data_c, sat_flag_c);
        mon(1, rd_valid_f, rd_data_f, sat_flag_f);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tx_start_packet    = '0;
        rx_start_packet    = '0;
        tx_error_underflow = '0;
        rx_error_bad_frame = '0;
        rx_error_bad_fcs   = '0;
        snap               = 1'b0;
        rd_req             = 1'b0;
    endtask

    task automatic rd(input int addr);
        rd_req  = 1'b1;
        rd_addr = AW'(addr);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        tx_start_packet = '1; rx_start_packet = '1;
        tx_error_underflow = '1; rx_error_bad_frame = '1; rx_error_bad_fcs = '1;
        snap = 1'b1; rd_req = 1'b1;
        tick();
        snap = 1'b1; rd_req = 1'b1; tx_start_packet = '1;
        tick();
        tick();
        rst = 1'b0;

        for (int a = 0; a < (1 << AW); a++) rd(a);

        // Channel 1 TX packets: 2+2+2+1 = 7.
        repeat (3) begin
            tx_start_packet[3:2] = 2'b11;
            tick();
        end
        tx_start_packet[3:2] = 2'b01;
        tick();
        snap = 1'b1;
        tick();
        rd(8);
        rd(0);

        // Saturate channel 2 RX bad FCS in the 8-bit counter.
        repeat (300) begin
            rx_error_bad_fcs[2] = 1'b1;
            tick();
        end
        snap = 1'b1;
        tick();
        rd(2*8 + STAT_RX_BAD_FCS);
        tick();

        // Snapshot coinciding with an RX start on channel 0.
        snap = 1'b1;
        tick();
        repeat (10) begin
            rx_start_packet[1:0] = 2'b01;
            tick();
        end
        rx_start_packet[1:0] = 2'b01;
        snap = 1'b1;
        tick();
        rd(STAT_RX_PKT);
        snap = 1'b1;
        tick();
        rd(STAT_RX_PKT);

        // Read and snap on the same cycle, then read again.
        repeat (3) begin
            tx_error_underflow[0] = 1'b1;
            tick();
        end
        snap = 1'b1;
        rd(STAT_TX_UNDERFLOW);
        rd(STAT_TX_UNDERFLOW);

        rd(6);
        rd(3*8);
        rd(31);

        // Reset during a read drops it.
        rd_req = 1'b1;
        rd_addr = AW'(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        for (int n = 0; n < 3000; n++) begin
            tx_start_packet    = 6'($urandom);
            rx_start_packet    = 6'($urandom);
            tx_error_underflow = 3'($urandom) & 3'($urandom);
            rx_error_bad_frame = 3'($urandom) & 3'($urandom);
            rx_error_bad_fcs   = 3'($urandom);
            snap    = ($urandom_range(0, 99) == 0);
            rd_req  = ($urandom_range(0, 1) == 0);
            rd_addr = AW'($urandom);
            rst     = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        repeat (3) tick();

        check("queue_drain", longint'(exp_q0.size() + exp_q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_mac_stats.md
# eth_mac_stats

Per-channel statistics block for the 10G MAC status outputs. It counts packet starts and error pulses from `N_CHANNELS` MAC instances (32- or 64-bit datapaths) in saturating counters. All live counters are captured atomically into a shadow bank on a snapshot strobe. Software reads the shadow bank through a registered single-word read port. It sits beside the MAC instances in the same clock domain, and any CDC happens upstream.

## Interface
- `N_CHANNELS`, default 4: number of MAC channels monitored, 1..16.
- `COUNTER_WIDTH`, default 32: width of every counter, 8..48.
- `CLEAR_ON_SNAP`, default 1: 1 = live counters restart from zero on snapshot; 0 = live counters free-run.
- `CH_BITS`, derived as max(1, clog2(N_CHANNELS)): width of the channel field in the address.
- `clk`  in  1  block clock; all MAC status inputs are synchronous to it.
- `rst`  in  1  synchronous, active-high reset.
- `tx_start_packet`  in  2*N_CHANNELS  per channel: 2 bits, lane-0 / lane-4 start pulses.
- `tx_error_underflow`  in  N_CHANNELS  per-channel pulse.
- `rx_start_packet`  in  2*N_CHANNELS  per channel: 2 bits, as TX.
- `rx_error_bad_frame`  in  N_CHANNELS  per-channel pulse.
- `rx_error_bad_fcs`  in  N_CHANNELS  per-channel pulse.
- `snap`  in  1  single-cycle snapshot strobe.
- `rd_req`  in  1  read strobe.
- `rd_addr`  in  CH_BITS+3  {channel, counter index}.
- `rd_valid`  out  1  read data valid, one-cycle pulse.
- `rd_data`  out  COUNTER_WIDTH  read result.
- `sat_flag`  out  N_CHANNELS  sticky: some counter of the channel has saturated.

## Operation
- Each channel has five counters, indexed as follows:
  - 0: TX packets
  - 1: TX underflow
  - 2: RX packets
  - 3: RX bad frame
  - 4: RX bad FCS
- Packet counters add popcount of the 2-bit start vector per cycle (0, 1 or 2). Error counters add 1 per asserted cycle.
- Saturation:
  - A counter whose sum would exceed 2^COUNTER_WIDTH-1 holds at all-ones.
  - The channel's `sat_flag` bit sets on the same cycle the counter saturates.
- Snapshot, on a `snap` cycle:
  - All 5*N_CHANNELS shadow registers load the live values, pre-increment for that cycle.
  - If CLEAR_ON_SNAP=1, each live counter loads that cycle's increment (0..2), so no event is lost, and `sat_flag` clears.
  - If CLEAR_ON_SNAP=0, live counters increment normally and `sat_flag` is unaffected.
- Read:
  - A `rd_req` cycle returns the shadow register addressed by `rd_addr`.
  - Counter index 5..7, or channel >= N_CHANNELS, returns 0 with `rd_valid` still pulsed.
- Back-to-back `rd_req` is allowed every cycle. There is no backpressure.

## Timing
- Reset: all live and shadow counters are 0, `sat_flag`=0, `rd_valid`=0, `rd_data`=0.
- A status pulse on cycle N is visible in the live counter at N+1. It reaches the shadow bank only via `snap`.
- `rd_req` on cycle N gives `rd_valid`=1 and `rd_data` valid on N+1.
  - `rd_data` holds its value until the next read.
  - `rd_valid` is 0 whenever there was no `rd_req` on the previous cycle.
- `rd_req` and `snap` on the same cycle: the read returns the pre-snap shadow contents. A read on the next cycle sees the new snapshot.
- `rst` asserted mid-read: `rd_valid` is 0 on the following cycle and the read is dropped.
- `snap` during `rst`: ignored.
- Saturated counter plus `snap` with CLEAR_ON_SNAP=1: the shadow gets all-ones, and live restarts at that cycle's increment.

## Structure
- Package `eth_mac_stats_pkg` holds:
  - counter index constants `STAT_TX_PKT`..`STAT_RX_BAD_FCS` (0..4);
  - `STAT_NUM`=5;
  - the index field width (3).
- Sub-module `eth_stat_counter` contains one saturating counter with a 2-bit increment, snapshot/clear and shadow register. It is instantiated 5*N_CHANNELS times in a generate loop.
- The top level contains only the increment decode, the registered read mux and `sat_flag` aggregation.

## Test plan
- Reset, then read all addresses: every `rd_data`=0, and `rd_valid` follows each `rd_req` by exactly 1 cycle.
- Channel 1: `tx_start_packet`=2'b11 for 3 cycles, 2'b01 for 1 cycle; `snap`; read {1,0} -> 7. The same read on channel 0 -> 0.
- COUNTER_WIDTH=8: 300 `rx_error_bad_fcs` pulses on channel 2 -> `sat_flag[2]`=1 at the 255th pulse; after `snap`, read -> 255. With CLEAR_ON_SNAP=1, `sat_flag[2]`=0 after the snap.
- `snap` coincident with `rx_start_packet`=2'b01 on channel 0, live=10: shadow=10. A second `snap` with no further events gives shadow=1 (CLEAR_ON_SNAP=1), or 11 (CLEAR_ON_SNAP=0).
- `rd_req` and `snap` on the same cycle -> old shadow value returned; a `rd_req` on the next cycle -> new value.
- Read index 6, and read channel N_CHANNELS when it is not a power of two -> `rd_valid`=1, `rd_data`=0.
